// File: rtl/test_run_pkg.sv
// Shared state encoding and exit-convention constants for the test run sequencer.
package test_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_SETTLE,
    ST_REPORT
  } state_t;

  localparam logic [31:0] EXIT_ECALL_ID = 32'd93;
  localparam logic [31:0] GP_DONE       = 32'd1;

endpackage

// File: rtl/run_watchdog.sv
// Loadable down-counter with a zero flag; a load takes priority over a decrement.
module run_watchdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/test_run_ctrl.sv
// Run sequencer: streams a program into IMEM, pulses CPU reset, runs until the
// exit convention or a cycle limit, then reports pass/fail/timeout and the cycle count.
module test_run_ctrl
  import test_run_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int IMEM_DEPTH    = 1024,
  parameter int RST_CYCLES    = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_CYCLES    = 1000,
  parameter int CYC_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  input  logic [31:0]       a7,
  input  logic [31:0]       gp,
  input  logic [31:0]       a0,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              load_ovf,
  output logic [31:0]       result,
  output logic [CYC_W-1:0]  cycles
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  state_t           state, state_nxt;
  logic             exit_hit;
  logic             wd_load, wd_dec, wd_zero;
  logic [CYC_W-1:0] wd_val;
  logic             clr_status, addr_inc, set_ovf, set_to, sample;
  logic             cnt_clr, cnt_en;

  assign exit_hit   = (a7 == EXIT_ECALL_ID) && (gp == GP_DONE);
  assign imem_we    = load_valid & load_ready;
  assign imem_wdata = load_data;

  run_watchdog #(.W(CYC_W)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (wd_val),
    .dec      (wd_dec),
    .zero     (wd_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    cpu_rst    = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    wd_load    = 1'b0;
    wd_val     = '0;
    wd_dec     = 1'b0;
    clr_status = 1'b0;
    addr_inc   = 1'b0;
    set_ovf    = 1'b0;
    set_to     = 1'b0;
    sample     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          clr_status = 1'b1;
          cnt_clr    = 1'b1;
          state_nxt  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          // The address saturates at the last index so a full IMEM never wraps.
          addr_inc = (imem_addr != LAST_ADDR);
          if (load_last || (imem_addr == LAST_ADDR)) begin
            set_ovf   = ~load_last;
            wd_load   = 1'b1;
            wd_val    = CYC_W'(RST_CYCLES - 1);
            cnt_clr   = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (wd_zero) begin
          wd_load   = 1'b1;
          wd_val    = CYC_W'(MAX_CYCLES - 1);
          state_nxt = ST_RUN;
        end else begin
          wd_dec = 1'b1;
        end
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        if (exit_hit) begin
          // Exit is tested first so it wins over a coincident timeout.
          wd_load   = 1'b1;
          wd_val    = CYC_W'(SETTLE_CYCLES - 1);
          cnt_en    = 1'b1;
          state_nxt = ST_SETTLE;
        end else if (wd_zero) begin
          set_to    = 1'b1;
          state_nxt = ST_REPORT;
        end else begin
          wd_dec = 1'b1;
          cnt_en = 1'b1;
        end
      end
      ST_SETTLE: begin
        cpu_rst = 1'b0;
        if (wd_zero) begin
          sample    = 1'b1;
          state_nxt = ST_REPORT;
        end else begin
          wd_dec = 1'b1;
          cnt_en = 1'b1;
        end
      end
      ST_REPORT: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The cycle count freezes on the edge into REPORT, so it reads the last run cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr <= '0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      load_ovf  <= 1'b0;
      result    <= '0;
      cycles    <= '0;
    end else begin
      if (clr_status) begin
        imem_addr <= '0;
        pass      <= 1'b0;
        timeout   <= 1'b0;
        load_ovf  <= 1'b0;
        result    <= '0;
      end
      if (addr_inc) imem_addr <= imem_addr + ADDR_W'(1);
      if (set_ovf)  load_ovf  <= 1'b1;
      if (set_to)   timeout   <= 1'b1;
      if (sample) begin
        result <= a0;
        pass   <= (a0 == '0);
      end
      if (cnt_clr)     cycles <= '0;
      else if (cnt_en) cycles <= cycles + CYC_W'(1);
    end
  end

endmodule

// File: tb/tb_test_run_ctrl.sv
// Bench for test_run_ctrl: scenario table plus randomized scenarios scored by a run-level model.
module tb_test_run_ctrl;

  localparam int MAXC = 1000;
  localparam int RSTC = 3;
  localparam int SETC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic [31:0] a7 = '0, gp = '0, a0 = '0;

  logic        load_ready, imem_we, cpu_rst, busy, done, pass, timeout, load_ovf;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata, result;
  logic [15:0] cycles;

  logic        s_load_ready, s_imem_we, s_cpu_rst, s_busy, s_done, s_pass, s_timeout, s_load_ovf;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata, s_result;
  logic [15:0] s_cycles;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          nwords;
    bit          gaps;
    int          exit_at;
    logic [31:0] a0_val;
    bit          mid_start;
    bit          exp_pass;
    bit          exp_to;
    logic [31:0] exp_result;
    int          exp_cycles;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] prog [0:7];

  test_run_ctrl #(.ADDR_W(10), .IMEM_DEPTH(1024), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC),
                  .MAX_CYCLES(MAXC), .CYC_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .a7(a7), .gp(gp), .a0(a0), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .load_ovf(load_ovf), .result(result),
    .cycles(cycles)
  );

  test_run_ctrl #(.ADDR_W(2), .IMEM_DEPTH(4), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC),
                  .MAX_CYCLES(MAXC), .CYC_W(16)) dut_small (
    .clk(clk), .rst(rst), .start(start), .load_valid(load_valid), .load_ready(s_load_ready),
    .load_data(load_data), .load_last(load_last), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .cpu_rst(s_cpu_rst), .a7(a7), .gp(gp), .a0(a0), .busy(s_busy),
    .done(s_done), .pass(s_pass), .timeout(s_timeout), .load_ovf(s_load_ovf), .result(s_result),
    .cycles(s_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Run-level model: outcome depends only on when the exit shows up and what a0 reads.
  function automatic vec_t model(int n, bit g, int e, logic [31:0] a0v, bit ms);
    vec_t v;
    v.nwords = n; v.gaps = g; v.exit_at = e; v.a0_val = a0v; v.mid_start = ms;
    if (e < 0) begin
      v.exp_pass = 1'b0; v.exp_to = 1'b1; v.exp_result = '0; v.exp_cycles = MAXC - 1;
    end else begin
      v.exp_pass = (a0v == 32'd0); v.exp_to = 1'b0; v.exp_result = a0v; v.exp_cycles = e + SETC;
    end
    return v;
  endfunction

  task automatic drive_taps(input vec_t v, input int r);
    if (v.exit_at >= 0 && r >= v.exit_at) begin
      a7 = 32'd93; gp = 32'd1;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin a7 = 32'd93; gp = 32'($urandom_range(2, 60)); end
        1:       begin a7 = 32'($urandom_range(0, 92)); gp = 32'd1; end
        default: begin a7 = $urandom; gp = $urandom | 32'h2; end
      endcase
    end
    a0 = (v.exit_at >= 0 && r == v.exit_at + SETC) ? v.a0_val : ($urandom | 32'h100);
  endtask

  task automatic run_test(input vec_t v);
    int done_at;
    done_at = v.exp_cycles + 1;
    next(); start = 1'b1; #2;
    chk_b("idle_busy", busy, 1'b0);
    chk_b("idle_ready", load_ready, 1'b0);
    chk_b("idle_cpu_rst", cpu_rst, 1'b1);
    for (int i = 0; i < v.nwords; i++) begin
      if (v.gaps) begin
        next(); start = 1'b0; load_valid = 1'b0; load_last = 1'b0; #2;
        chk_b("gap_ready", load_ready, 1'b1);
        chk_b("gap_we", imem_we, 1'b0);
      end
      next(); start = 1'b0; load_valid = 1'b1; load_data = prog[i];
      load_last = (i == v.nwords - 1); #2;
      if (i == 0) begin
        chk_b("clr_pass", pass, 1'b0);
        chk_b("clr_timeout", timeout, 1'b0);
        chk("clr_result", result, 32'd0);
        chk("clr_cycles", 32'(cycles), 32'd0);
      end
      chk_b("load_ready", load_ready, 1'b1);
      chk_b("load_we", imem_we, 1'b1);
      chk("load_addr", 32'(imem_addr), i);
      chk("load_wdata", imem_wdata, prog[i]);
      chk_b("load_cpu_rst", cpu_rst, 1'b1);
    end
    for (int k = 0; k < RSTC; k++) begin
      next(); load_valid = 1'b0; load_last = 1'b0; #2;
      chk_b("hold_cpu_rst", cpu_rst, 1'b1);
      chk_b("hold_ready", load_ready, 1'b0);
      chk_b("hold_busy", busy, 1'b1);
    end
    for (int r = 0; r <= done_at; r++) begin
      next();
      start = v.mid_start && (r == 100);
      drive_taps(v, r);
      #2;
      chk_b("run_done", done, r == done_at);
      chk_b("run_cpu_rst", cpu_rst, r == done_at);
      chk("run_cycles", 32'(cycles), (r < done_at) ? r : v.exp_cycles);
    end
    chk_b("rep_pass", pass, v.exp_pass);
    chk_b("rep_timeout", timeout, v.exp_to);
    chk("rep_result", result, v.exp_result);
    chk_b("rep_load_ovf", load_ovf, 1'b0);
    for (int k = 0; k < 3; k++) begin
      next(); start = 1'b0; #2;
      chk_b("post_busy", busy, 1'b0);
      chk_b("post_done", done, 1'b0);
      chk_b("post_pass", pass, v.exp_pass);
      chk("post_result", result, v.exp_result);
      chk("post_cycles", 32'(cycles), v.exp_cycles);
    end
  endtask

  initial begin
    int nwr;
    vecs[0] = '{4, 1'b1, 40,  32'd0,       1'b0, 1'b1, 1'b0, 32'd0,       42};
    vecs[1] = '{4, 1'b0, 40,  32'd7,       1'b0, 1'b0, 1'b0, 32'd7,       42};
    vecs[2] = '{4, 1'b0, -1,  32'd0,       1'b1, 1'b0, 1'b1, 32'd0,       999};
    vecs[3] = '{4, 1'b1, 999, 32'd0,       1'b0, 1'b1, 1'b0, 32'd0,       1001};
    vecs[4] = '{4, 1'b0, 0,   32'hdead,    1'b0, 1'b0, 1'b0, 32'hdead,    2};

    // Reset values, both while rst is held and after release.
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin rst = 1'b0; next(); end
      #2;
      chk_b("rst_cpu_rst", cpu_rst, 1'b1);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk_b("rst_ready", load_ready, 1'b0);
      chk_b("rst_we", imem_we, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_done", done, 1'b0);
      chk_b("rst_pass", pass, 1'b0);
      chk_b("rst_timeout", timeout, 1'b0);
      chk_b("rst_ovf", load_ovf, 1'b0);
      chk("rst_result", result, 32'd0);
      chk("rst_cycles", 32'(cycles), 32'd0);
      chk_b("rst_s_cpu_rst", s_cpu_rst, 1'b1);
      chk("rst_s_addr", 32'(s_imem_addr), 32'd0);
      chk_b("rst_s_busy", s_busy, 1'b0);
      chk_b("rst_s_flags", s_load_ready | s_imem_we | s_done | s_pass | s_timeout | s_load_ovf, 1'b0);
      chk("rst_s_result", s_result, 32'd0);
      chk("rst_s_cycles", 32'(s_cycles), 32'd0);
      chk("rst_s_wdata", s_imem_wdata, load_data);
    end

    prog[0] = 32'h00500093; prog[1] = 32'h00100193;
    prog[2] = 32'h05d00893; prog[3] = 32'h00000513;
    for (int t = 0; t < 5; t++) run_test(vecs[t]);

    for (int t = 0; t < 6; t++) begin
      int n, e;
      logic [31:0] av;
      bit g, ms;
      n  = int'($urandom_range(1, 8));
      g  = ($urandom_range(0, 1) == 1);
      ms = ($urandom_range(0, 1) == 1);
      e  = int'($urandom_range(0, 1150));
      if (e >= MAXC) e = -1;
      av = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      run_test(model(n, g, e, av, ms));
    end

    // Overflow: 4-deep IMEM fed 6 words with no last marker.
    rst = 1'b1; next(); rst = 1'b0;
    next(); start = 1'b1;
    next(); start = 1'b0;
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1; load_last = 1'b0; load_data = 32'h100 + 32'(i); #2;
      if (s_imem_we) begin
        nwr++;
        chk("ovf_addr", 32'(s_imem_addr), i);
      end
      next();
    end
    load_valid = 1'b0; #2;
    chk("ovf_writes", 32'(nwr), 32'd4);
    chk_b("ovf_flag", s_load_ovf, 1'b1);
    chk("ovf_addr_held", 32'(s_imem_addr), 32'd3);
    chk_b("ovf_ready", s_load_ready, 1'b0);
    chk_b("ovf_cpu_rst", s_cpu_rst, 1'b1);
    chk_b("no_ovf_big", load_ovf, 1'b0);

    // Asynchronous reset during SETTLE aborts without a done pulse.
    rst = 1'b1; next(); rst = 1'b0;
    next(); start = 1'b1;
    next(); start = 1'b0; load_valid = 1'b1; load_data = 32'h13; load_last = 1'b1;
    next(); load_valid = 1'b0; load_last = 1'b0;
    next(); next();
    for (int r = 0; r <= 4; r++) begin
      next();
      a7 = (r >= 3) ? 32'd93 : 32'd0; gp = 32'd1; a0 = 32'd5;
    end
    #2;
    chk_b("settle_cpu_rst", cpu_rst, 1'b0);
    chk_b("settle_busy", busy, 1'b1);
    chk("settle_cycles", 32'(cycles), 32'd4);
    rst = 1'b1; #1;
    chk_b("arst_busy", busy, 1'b0);
    chk_b("arst_cpu_rst", cpu_rst, 1'b1);
    chk_b("arst_done", done, 1'b0);
    chk("arst_cycles", 32'(cycles), 32'd0);
    next(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next(); #2;
      chk_b("arst_no_done", done, 1'b0);
      chk_b("arst_idle", busy, 1'b0);
    end
    chk("arst_result", result, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/test_run_ctrl.md
Name: test_run_ctrl

Overview:
- Synthesizable run sequencer for the pipelined RISC-V core, so that regression tests can run on an FPGA without a simulator.
- Streams a test program into instruction memory, holds the core in reset, then releases it.
- Watches the exit convention (a7/x17 = 93 and gp/x3 = 1), waits a settle window, then samples a0/x10 as the result.
- Reports pass, fail or timeout, plus the cycle count. Sits between a host/UART loader and the cpu_top/IMEM write port.

Parameters:
- ADDR_W, 10, IMEM word-address width.
- IMEM_DEPTH, 1024, IMEM depth in words; the last loadable index is IMEM_DEPTH-1.
- RST_CYCLES, 3, number of cycles cpu_rst is held after the load completes.
- SETTLE_CYCLES, 2, cycles waited after the exit condition before a0 is sampled.
- MAX_CYCLES, 1000, run cycles before a timeout is declared.
- CYC_W, 16, cycle-counter width; must satisfy 2^CYC_W > MAX_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a test; honoured only in IDLE
- load_valid  in  1  program word valid
- load_ready  out  1  controller accepts a word
- load_data  in  32  instruction word
- load_last  in  1  final word of the program
- imem_we  out  1  IMEM write enable
- imem_addr  out  ADDR_W  IMEM word address
- imem_wdata  out  32  IMEM write data
- cpu_rst  out  1  reset to cpu_top
- a7  in  32  register x17 debug tap
- gp  in  32  register x3 debug tap
- a0  in  32  register x10 debug tap
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse
- pass  out  1  a0 was 0 at sample time
- timeout  out  1  run limit was hit
- load_ovf  out  1  IMEM filled before load_last arrived
- result  out  32  sampled a0
- cycles  out  CYC_W  run cycles consumed

Behaviour:
- Reset values:
  - State IDLE; cpu_rst=1; imem_addr=0.
  - load_ready, imem_we, busy, done, pass, timeout, load_ovf all 0.
  - result=0, cycles=0.
  - Reset is asynchronous; asserting rst mid-test aborts to IDLE at once, with no done pulse.
- States: IDLE, LOAD, HOLD, RUN, SETTLE, REPORT.
- IDLE:
  - cpu_rst=1.
  - start=1 → LOAD next cycle; clears pass, timeout, load_ovf, result and cycles; sets imem_addr=0.
  - start in any other state is ignored.
- LOAD:
  - load_ready=1.
  - imem_we = load_valid & load_ready, combinational, same cycle.
  - imem_wdata = load_data, passthrough.
  - Each accepted word increments imem_addr on the next edge.
  - Accepted word with load_last=1 → HOLD.
  - Accepted word at imem_addr=IMEM_DEPTH-1 without load_last → word is written, load_ovf=1, → HOLD.
  - No wrap-around.
- HOLD:
  - cpu_rst=1 for exactly RST_CYCLES cycles (internal counter), then → RUN.
  - cycles=0 on entry.
- RUN:
  - cpu_rst=0; cycles increments every cycle.
  - Exit condition: a7==93 and gp==1, checked every cycle → SETTLE.
  - cycles==MAX_CYCLES-1 without the exit condition → timeout=1, → REPORT.
  - Exit condition and timeout in the same cycle: exit wins, timeout stays 0.
- SETTLE:
  - cpu_rst=0 and cycles keeps counting.
  - After SETTLE_CYCLES cycles: result=a0, pass=(a0==0), → REPORT.
- REPORT:
  - done=1 for this single cycle, cpu_rst=1, → IDLE.
- Status hold: pass, timeout, load_ovf, result and cycles hold until the next accepted start.
- busy=1 in every state except IDLE.
- Latency: start → first load_ready is 1 cycle.

Decomposition:
- Package test_run_pkg:
  - state enum;
  - EXIT_ECALL_ID=93, GP_DONE=1.
- One natural sub-module, run_watchdog: a loadable down-counter with a zero flag, shared by the HOLD, RUN and SETTLE timing.

Test Plan:
- Reset cluster (assert rst, then release):
  - all outputs take their reset values, with cpu_rst=1.
- Load handshake: load 4 words 0x00500093, 0x00100193, 0x05d00893, 0x00000513 (last=1), with 1-cycle valid gaps →
  - writes land at addr 0..3;
  - cpu_rst is high for 3 cycles, then low.
- Pass case: drive the taps a7=93, gp=1, a0=0 at run cycle 40 →
  - done pulses 1 cycle at cycle 42;
  - pass=1, timeout=0, result=0.
- Fail case: same as pass, but a0=7 →
  - pass=0, result=7.
- Timeout case: taps never match →
  - done pulses with timeout=1 and cycles=999;
  - start issued mid-RUN has no effect.
- Boundaries:
  - IMEM_DEPTH=4, stream 6 words with no last → load_ovf=1, only 4 writes occur;
  - exit condition on cycle 999 → pass path taken, timeout=0;
  - rst during SETTLE → IDLE, no done pulse.
